// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - DEPTH x WIDTH register file, RMW write port, two registered read ports with write bypass
module reg_file_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             en,
    input  logic [1:0]       wop,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rsel0,
    input  logic [AW-1:0]    rsel1,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             v0,
    output logic             v1,
    output logic             ovf
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid;

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic             wr_ok;

    logic [WIDTH-1:0] rq0;
    logic [WIDTH-1:0] rq1;
    logic             rv0;
    logic             rv1;

    // Read-modify-write result for the addressed entry
    always_comb begin
        cur   = mem[wsel];
        sum   = {1'b0, cur} + {1'b0, d};
        nxt   = cur;
        carry = 1'b0;
        case (wop)
            OP_LOAD: nxt = d;
            OP_ADD: begin
                nxt   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_OR:   nxt = cur | d;
            OP_ANDN: nxt = cur & ~d;
            default: nxt = cur;
        endcase
        wr_ok = en && !(ZERO_REG && (wsel == '0));
    end

    // Read port 0: hard-wired zero entry, then write-first bypass, then storage
    always_comb begin
        rq0 = mem[rsel0];
        rv0 = valid[rsel0];
        if (ZERO_REG && (rsel0 == '0)) begin
            rq0 = '0;
            rv0 = 1'b1;
        end else if (wr_ok && (rsel0 == wsel)) begin
            rq0 = nxt;
            rv0 = 1'b1;
        end
    end

    always_comb begin
        rq1 = mem[rsel1];
        rv1 = valid[rsel1];
        if (ZERO_REG && (rsel1 == '0)) begin
            rq1 = '0;
            rv1 = 1'b1;
        end else if (wr_ok && (rsel1 == wsel)) begin
            rq1 = nxt;
            rv1 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
            q0    <= '0;
            q1    <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            ovf   <= 1'b0;
        end else if (sclr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
            q0    <= '0;
            q1    <= '0;
            v0    <= 1'b0;
            v1    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wsel]   <= nxt;
                valid[wsel] <= 1'b1;
            end
            ovf <= wr_ok && (wop == OP_ADD) && carry;
            q0  <= rq0;
            q1  <= rq1;
            v0  <= rv0;
            v1  <= rv1;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param (ZERO_REG=0 and ZERO_REG=1 builds)
module tb_reg_file_param;

    localparam int W = 8;
    localparam int D = 8;
    localparam int A = 3;

    logic         clk = 1'b0;
    logic         clr_n, sclr, en;
    logic [1:0]   wop;
    logic [A-1:0] wsel, rsel0, rsel1;
    logic [W-1:0] d;

    logic [W-1:0] q0a, q1a, q0b, q1b;
    logic         v0a, v1a, ovfa, v0b, v1b, ovfb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b0)) dut (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .en(en), .wop(wop), .wsel(wsel), .d(d),
        .rsel0(rsel0), .rsel1(rsel1), .q0(q0a), .q1(q1a), .v0(v0a), .v1(v1a), .ovf(ovfa)
    );

    reg_file_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .en(en), .wop(wop), .wsel(wsel), .d(d),
        .rsel0(rsel0), .rsel1(rsel1), .q0(q0b), .q1(q1b), .v0(v0b), .v1(v1b), .ovf(ovfb)
    );

    typedef struct {
        logic         sclr;
        logic         en;
        logic [1:0]   wop;
        logic [A-1:0] wsel;
        logic [W-1:0] d;
        logic [A-1:0] r0;
        logic [A-1:0] r1;
        logic [18:0]  exp;
    } vec_t;

    typedef struct {
        logic        z;
        logic [18:0] exp;
        string       name;
    } sb_t;

    vec_t vecs[16];
    sb_t  sbq[$];

    function automatic logic [18:0] pk(logic [7:0] eq0, logic [7:0] eq1, logic ev0, logic ev1, logic eovf);
        return {eq0, eq1, ev0, ev1, eovf};
    endfunction

    function automatic vec_t mk(logic s, logic e, logic [1:0] op, logic [2:0] ws, logic [7:0] dd,
                                logic [2:0] r0, logic [2:0] r1, logic [18:0] exp);
        vec_t v;
        v.sclr = s; v.en = e; v.wop = op; v.wsel = ws; v.d = dd; v.r0 = r0; v.r1 = r1; v.exp = exp;
        return v;
    endfunction

    function automatic logic [18:0] obs(logic z);
        return z ? {q0b, q1b, v0b, v1b, ovfb} : {q0a, q1a, v0a, v1a, ovfa};
    endfunction

    task automatic chk(string name, logic [18:0] act, logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got q0/q1/v0/v1/ovf=%h/%h/%b/%b/%b expected %h/%h/%b/%b/%b",
                     name, act[18:11], act[10:3], act[2], act[1], act[0],
                     exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(logic s, logic e, logic [1:0] op, logic [2:0] ws, logic [7:0] dd,
                         logic [2:0] r0, logic [2:0] r1);
        @(negedge clk);
        sclr = s; en = e; wop = op; wsel = ws; d = dd; rsel0 = r0; rsel1 = r1;
    endtask

    task automatic expect_out(logic z, string name, logic [18:0] exp);
        sb_t s;
        s.z = z; s.exp = exp; s.name = name;
        sbq.push_back(s);
    endtask

    task automatic step();
        sb_t s;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk(s.name, obs(s.z), s.exp);
        end
    endtask

    initial begin
        vecs[0]  = mk(0, 1, 2'b00, 1, 8'h03, 5, 5, pk(8'h00, 8'h00, 0, 0, 0));
        vecs[1]  = mk(0, 1, 2'b00, 3, 8'h83, 1, 5, pk(8'h03, 8'h00, 1, 0, 0));
        vecs[2]  = mk(0, 0, 2'b00, 0, 8'h00, 1, 3, pk(8'h03, 8'h83, 1, 1, 0));
        vecs[3]  = mk(0, 1, 2'b00, 2, 8'hF0, 2, 3, pk(8'hF0, 8'h83, 1, 1, 0));
        vecs[4]  = mk(0, 1, 2'b01, 2, 8'h20, 2, 1, pk(8'h10, 8'h03, 1, 1, 1));
        vecs[5]  = mk(0, 1, 2'b10, 2, 8'h0F, 2, 2, pk(8'h1F, 8'h1F, 1, 1, 0));
        vecs[6]  = mk(0, 1, 2'b11, 2, 8'h11, 2, 0, pk(8'h0E, 8'h00, 1, 0, 0));
        vecs[7]  = mk(0, 1, 2'b00, 4, 8'h5A, 4, 4, pk(8'h5A, 8'h5A, 1, 1, 0));
        vecs[8]  = mk(0, 1, 2'b01, 3, 8'h01, 3, 2, pk(8'h84, 8'h0E, 1, 1, 0));
        vecs[9]  = mk(0, 0, 2'b01, 3, 8'hFF, 3, 4, pk(8'h84, 8'h5A, 1, 1, 0));
        vecs[10] = mk(0, 1, 2'b01, 3, 8'hFF, 5, 6, pk(8'h00, 8'h00, 0, 0, 1));
        vecs[11] = mk(0, 0, 2'b00, 0, 8'h00, 3, 7, pk(8'h83, 8'h00, 1, 0, 0));
        vecs[12] = mk(0, 1, 2'b00, 0, 8'h07, 0, 0, pk(8'h07, 8'h07, 1, 1, 0));
        vecs[13] = mk(1, 1, 2'b00, 1, 8'hAA, 1, 0, pk(8'h00, 8'h00, 0, 0, 0));
        vecs[14] = mk(0, 0, 2'b00, 0, 8'h00, 1, 3, pk(8'h00, 8'h00, 0, 0, 0));
        vecs[15] = mk(0, 0, 2'b00, 0, 8'h00, 0, 4, pk(8'h00, 8'h00, 0, 0, 0));

        clr_n = 1'b1; sclr = 1'b0; en = 1'b1; wop = 2'b00; wsel = 3'd1; d = 8'h3C;
        rsel0 = 3'd1; rsel1 = 3'd2;
        #1 clr_n = 1'b0;
        #1;
        chk("reset_dut", obs(1'b0), pk(8'h00, 8'h00, 0, 0, 0));
        chk("reset_dut_z", obs(1'b1), pk(8'h00, 8'h00, 0, 0, 0));
        @(negedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].sclr, vecs[i].en, vecs[i].wop, vecs[i].wsel, vecs[i].d, vecs[i].r0, vecs[i].r1);
            expect_out(1'b0, $sformatf("vec%0d", i), vecs[i].exp);
            step();
        end

        apply(0, 1, 2'b00, 0, 8'hFF, 0, 0);
        expect_out(1'b1, "zreg_write0", pk(8'h00, 8'h00, 1, 1, 0));
        expect_out(1'b0, "plain_write0", pk(8'hFF, 8'hFF, 1, 1, 0));
        step();
        apply(0, 1, 2'b00, 6, 8'h3C, 0, 6);
        expect_out(1'b1, "zreg_mixed", pk(8'h00, 8'h3C, 1, 1, 0));
        expect_out(1'b0, "plain_mixed", pk(8'hFF, 8'h3C, 1, 1, 0));
        step();
        apply(1, 0, 2'b00, 0, 8'h00, 0, 6);
        expect_out(1'b1, "zreg_sclr", pk(8'h00, 8'h00, 0, 0, 0));
        expect_out(1'b0, "plain_sclr", pk(8'h00, 8'h00, 0, 0, 0));
        step();
        apply(0, 0, 2'b00, 0, 8'h00, 0, 6);
        expect_out(1'b1, "zreg_after_sclr", pk(8'h00, 8'h00, 1, 0, 0));
        expect_out(1'b0, "plain_after_sclr", pk(8'h00, 8'h00, 0, 0, 0));
        step();

        apply(0, 1, 2'b00, 5, 8'h77, 5, 5);
        expect_out(1'b0, "pre_reset_write", pk(8'h77, 8'h77, 1, 1, 0));
        step();
        apply(0, 1, 2'b01, 5, 8'hF0, 5, 5);
        #2 clr_n = 1'b0;
        #1;
        chk("async_reset_dut", obs(1'b0), pk(8'h00, 8'h00, 0, 0, 0));
        chk("async_reset_dut_z", obs(1'b1), pk(8'h00, 8'h00, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1; en = 1'b0; rsel0 = 3'd5; rsel1 = 3'd6;
        expect_out(1'b0, "post_reset_read", pk(8'h00, 8'h00, 0, 0, 0));
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
